dac_frame_buffer: RTL and testbench

DAC_FRAME_BUFFER -- requirements
Module: dac_frame_buffer

---
 rtl/dac_frame_buffer.sv | 190 +++++++++++++++++++
 tb/tb_dac_frame_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_buffer.sv
// ---------------------------------------------------------------------------
// dac_frame_buffer
//   Double-buffered (ping-pong) sample store between a host writer and a DAC
//   slot sequencer. The host fills the write bank (~SEL) while the sequencer
//   reads the other bank (registered SEL) one slot address at a time.
//
// Optional feature:
//   DAC_MIDSCALE_SYNC_EN - when defined, the frame-sync slot (ADR==FRAME_LEN)
//   loads the midscale code into dac_data two cycles after the address event.
//   When undefined, dac_data holds the last data-slot value through the sync
//   slot.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   ADR[6:0]   in   slot address: 0..FRAME_LEN-1 data, FRAME_LEN sync
//   SEL        in   bank select, toggles once per frame
//   wr_valid   in   host sample valid
//   wr_data    in   host sample
//   wr_ready   out  buffer accepts a sample this cycle
//   dac_data   out  registered DAC sample
//   dac_strobe out  one-cycle pulse marking a new dac_data value
//   underrun   out  one-cycle pulse: bank swap before write bank was full
// ---------------------------------------------------------------------------
module dac_frame_buffer #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        ADR,
  input  logic              SEL,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe,
  output logic              underrun
);

  localparam int              AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0]   LAST_PTR = AW'(FRAME_LEN - 1);
  localparam logic [6:0]      SYNC_ADR = 7'(FRAME_LEN);
`ifdef DAC_MIDSCALE_SYNC_EN
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  // Two banks; bank index 0/1 matches the SEL encoding.
  logic [DATA_W-1:0] mem_r [0:1][0:FRAME_LEN-1];

  wr_state_t         state_r;
  logic              wr_ready_r;
  logic [AW-1:0]     wptr_r;
  logic              sel_q_r;
  logic [6:0]        adr_q_r;
  logic              underrun_r;

  logic [DATA_W-1:0] rd_data_r;
  logic              rd_strobe_r;
`ifdef DAC_MIDSCALE_SYNC_EN
  logic              rd_sync_r;
  logic              sync_event_s;
`endif
  logic [DATA_W-1:0] dac_data_r;
  logic              dac_strobe_r;

  logic              sel_change_s;
  logic              wr_accept_s;
  logic              last_write_s;
  logic              wr_bank_s;
  logic              adr_event_s;
  logic              data_event_s;
  logic [AW-1:0]     rd_idx_s;

  assign sel_change_s = (SEL != sel_q_r);
  // wr_ready_r tracks the FSM state; the reset term keeps ready low during reset.
  assign wr_accept_s  = wr_ready_r & wr_valid & ~reset;
  assign last_write_s = (wptr_r == LAST_PTR);
  // Writes use the bank opposite the registered SEL, so a final write that
  // coincides with a SEL change still lands in the outgoing write bank, and
  // reads (bank sel_q_r) never share a bank with writes.
  assign wr_bank_s    = ~sel_q_r;
  assign adr_event_s  = (ADR != adr_q_r);
  assign data_event_s = adr_event_s & (ADR < SYNC_ADR);
  assign rd_idx_s     = ADR[AW-1:0];
`ifdef DAC_MIDSCALE_SYNC_EN
  assign sync_event_s = adr_event_s & (ADR == SYNC_ADR);
`endif

  // Writer FSM: fill pointer, bank-swap tracking and underrun detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= FILL;
      wr_ready_r <= 1'b1;
      wptr_r     <= '0;
      sel_q_r    <= SEL;
      underrun_r <= 1'b0;
    end else begin
      sel_q_r    <= SEL;
      // A swap is only an underrun if the bank was neither full nor being
      // completed by a coincident final write.
      underrun_r <= sel_change_s & (state_r == FILL) & ~(wr_accept_s & last_write_s);
      if (sel_change_s) begin
        state_r    <= FILL;
        wr_ready_r <= 1'b1;
        wptr_r     <= '0;
      end else begin
        case (state_r)
          FILL: begin
            if (wr_accept_s) begin
              if (last_write_s) begin
                state_r    <= FULL;
                wr_ready_r <= 1'b0;
                wptr_r     <= '0;
              end else begin
                wptr_r     <= wptr_r + AW'(1);
              end
            end
          end
          FULL: begin
            wr_ready_r <= 1'b0;
          end
          default: begin
            state_r    <= FILL;
            wr_ready_r <= 1'b1;
            wptr_r     <= '0;
          end
        endcase
      end
    end
  end

  // Sample storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_bank_s][wptr_r] <= wr_data;
    end
  end

  // Read stage 1: address-change detection and synchronous RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q_r     <= ADR;
      rd_data_r   <= '0;
      rd_strobe_r <= 1'b0;
`ifdef DAC_MIDSCALE_SYNC_EN
      rd_sync_r   <= 1'b0;
`endif
    end else begin
      adr_q_r     <= ADR;
      rd_strobe_r <= data_event_s;
`ifdef DAC_MIDSCALE_SYNC_EN
      rd_sync_r   <= sync_event_s;
`endif
      if (data_event_s) begin
        rd_data_r <= mem_r[sel_q_r][rd_idx_s];
      end
    end
  end

  // Read stage 2: DAC output register and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_data_r   <= '0;
      dac_strobe_r <= 1'b0;
    end else if (rd_strobe_r) begin
      dac_data_r   <= rd_data_r;
      dac_strobe_r <= 1'b1;
`ifdef DAC_MIDSCALE_SYNC_EN
    end else if (rd_sync_r) begin
      dac_data_r   <= MIDSCALE;
      dac_strobe_r <= 1'b0;
`endif
    end else begin
      dac_data_r   <= dac_data_r;
      dac_strobe_r <= 1'b0;
    end
  end

  assign wr_ready   = wr_ready_r & ~reset;
  assign dac_data   = dac_data_r;
  assign dac_strobe = dac_strobe_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_dac_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_dac_frame_buffer
//   Directed stimulus for dac_frame_buffer (default parameters). Read-side
//   expectations (cycle of strobe, sample value) are queued when an ADR change
//   is issued and popped by an independent monitor whenever dac_strobe is seen.
// ---------------------------------------------------------------------------
module tb_dac_frame_buffer;

  logic        clk;
  logic        reset;
  logic [6:0]  ADR;
  logic        SEL;
  logic        wr_valid;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic [11:0] dac_data;
  logic        dac_strobe;
  logic        underrun;

  typedef struct {
    int          cyc;
    logic [11:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   tests;
  int   fails;
  int   under_seen;
  int   under_exp;

  dac_frame_buffer #(.DATA_W(12), .FRAME_LEN(80)) dut (
    .clk        (clk),
    .reset      (reset),
    .ADR        (ADR),
    .SEL        (SEL),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .dac_data   (dac_data),
    .dac_strobe (dac_strobe),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, counts underrun pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) under_seen++;
      if (dac_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(dac_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("dac_data", 32'(dac_data), 32'(e.data));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream n samples base..base+n-1 with wr_valid held; optional SEL toggle
  // coincident with the last sample.
  task automatic write_seq(input int base, input int n, input bit tog_last);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = 12'(base + i);
      if (tog_last && i == n - 1) SEL = ~SEL;
      chk("wr_ready_fill", 32'(wr_ready), 32'd1);
      step(1);
    end
    wr_valid = 1'b0;
  endtask

  // Step ADR through 0..n-1, two cycles per slot, queueing expected samples.
  task automatic read_frame(input int base, input int n);
    exp_t e;
    for (int a = 0; a < n; a++) begin
      ADR    = 7'(a);
      e.cyc  = cyc + 2;
      e.data = 12'(base + a);
      exp_q.push_back(e);
      step(2);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [11:0] sync_val;
    cyc = 0; tests = 0; fails = 0; under_seen = 0; under_exp = 0;
    reset = 1'b1; ADR = 7'd5; SEL = 1'b0; wr_valid = 1'b0; wr_data = 12'd0;

    // Reset state
    step(2);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_dac_data", 32'(dac_data), 32'd0);
    chk("rst_dac_strobe", 32'(dac_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    step(1);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    step(3);

    // Fill bank 1 with 0..79, wr_valid held past the end
    wr_valid = 1'b1;
    write_seq(0, 80, 1'b0);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 12'd999;
    step(2);
    wr_valid = 1'b0;
    chk("full_stays", 32'(wr_ready), 32'd0);
    chk("underrun_none_fill", 32'(under_seen), 32'(under_exp));

    // Sync slot before any data slot
    ADR = 7'd80;
    step(4);
`ifdef DAC_MIDSCALE_SYNC_EN
    chk("sync_first", 32'(dac_data), 32'h800);
`else
    chk("sync_first", 32'(dac_data), 32'd0);
`endif

    // Swap (bank full, no underrun) and read frame 0..79
    SEL = 1'b1;
    step(2);
    chk("swap_full_no_underrun", 32'(under_seen), 32'(under_exp));
    read_frame(0, 80);
    drain();

    // Sync slot and out-of-range address
    ADR = 7'd80;
    step(4);
`ifdef DAC_MIDSCALE_SYNC_EN
    sync_val = 12'h800;
`else
    sync_val = 12'd79;
`endif
    chk("sync_slot", 32'(dac_data), 32'(sync_val));
    ADR = 7'd100;
    step(4);
    chk("adr_above_sync", 32'(dac_data), 32'(sync_val));

    // Partial fill of 40 then swap -> underrun
    write_seq(100, 40, 1'b0);
    SEL = 1'b0;
    under_exp++;
    step(3);
    chk("underrun_partial", 32'(under_seen), 32'(under_exp));
    chk("swap_wr_ready", 32'(wr_ready), 32'd1);

    // Full frame into bank 1 with final write coincident with swap
    write_seq(200, 80, 1'b1);
    step(3);
    chk("coincident_no_underrun", 32'(under_seen), 32'(under_exp));
    chk("coincident_wr_ready", 32'(wr_ready), 32'd1);
    read_frame(200, 80);
    drain();

    // Reset after 30 writes into bank 0
    write_seq(300, 30, 1'b0);
    reset = 1'b1;
    step(1);
    chk("midrst_dac_data", 32'(dac_data), 32'd0);
    chk("midrst_strobe", 32'(dac_strobe), 32'd0);
    chk("midrst_underrun", 32'(underrun), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    step(1);
    write_seq(400, 1, 1'b0);
    SEL = 1'b0;
    under_exp++;
    step(3);
    chk("underrun_after_rst", 32'(under_seen), 32'(under_exp));
    ADR    = 7'd0;
    e.cyc  = cyc + 2;
    e.data = 12'd400;
    exp_q.push_back(e);
    step(2);
    ADR    = 7'd1;
    e.cyc  = cyc + 2;
    e.data = 12'd301;
    exp_q.push_back(e);
    step(2);
    drain();
    step(4);
    chk("underrun_final", 32'(under_seen), 32'(under_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
